// File: rtl/led_pattern_driver.sv
// Multi-channel LED driver: per-channel off/on/blink/PWM from one shared free-running counter.
// Optional triangle-wave breathe ramp per channel when LED_BREATHE_EN is defined.
module led_pattern_driver #(
   parameter int NUM_LEDS      = 4,
   parameter int CNT_WIDTH     = 32,
   parameter int BLINK_BIT     = 23,
   parameter int PWM_BITS      = 8,
   parameter int BREATHE_SHIFT = 16,
   localparam int CH_W         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                pin_clk_16M,
   input  logic                pin_reset_n,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   input  logic                cfg_invert,
   input  logic                cfg_breathe,
   output logic                cfg_ack,
   output logic                cfg_err,
   output logic [NUM_LEDS-1:0] leds
);

   // One extra bit so NUM_LEDS itself is representable for the range compare
   localparam logic [CH_W:0] NUM_CH = (CH_W + 1)'(NUM_LEDS);

   logic [CNT_WIDTH-1:0] r_count;
   logic [NUM_LEDS-1:0]  r_leds;
   logic [NUM_LEDS-1:0]  w_led_nxt;
   logic                 r_ack;
   logic                 r_err;
   logic                 w_chan_ok;
   logic                 w_wr_ok;
   logic                 w_wr_bad;
   logic                 w_unused;

   assign w_chan_ok = ({1'b0, cfg_chan} < NUM_CH);
   assign w_wr_ok   = cfg_we & w_chan_ok;
   assign w_wr_bad  = cfg_we & ~w_chan_ok;
   assign w_unused  = ^{r_count, cfg_breathe};

   assign cfg_ack = r_ack;
   assign cfg_err = r_err;
   assign leds    = r_leds;

   always_ff @(negedge pin_clk_16M) begin
      if (!pin_reset_n) begin
         r_count <= '0;
         r_leds  <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_count <= r_count + CNT_WIDTH'(1);
         r_leds  <= w_led_nxt;
         r_ack   <= w_wr_ok;
         r_err   <= w_wr_bad;
      end
   end

`ifdef LED_BREATHE_EN
   // Ramp direction FSM, one instance per channel:
   //   state     | meaning
   //   RAMP_UP   | ramp counts up toward all-ones
   //   RAMP_DOWN | ramp counts down toward zero
   typedef enum logic {RAMP_UP = 1'b0, RAMP_DOWN = 1'b1} ramp_dir_t;

   logic w_step;
   assign w_step = &r_count[BREATHE_SHIFT-1:0];
`endif

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
      logic [1:0]          r_mode;
      logic [PWM_BITS-1:0] r_duty;
      logic                r_invert;
      logic                w_sel;
      logic [PWM_BITS-1:0] w_eff_duty;
      logic                w_led;

      assign w_sel = w_wr_ok && (cfg_chan == CH_W'(i));

      always_ff @(negedge pin_clk_16M) begin
         if (!pin_reset_n) begin
            r_mode   <= 2'd0;
            r_duty   <= '0;
            r_invert <= 1'b0;
         end else if (w_sel) begin
            r_mode   <= cfg_mode;
            r_duty   <= cfg_duty;
            r_invert <= cfg_invert;
         end
      end

`ifdef LED_BREATHE_EN
      ramp_dir_t           r_dir;
      ramp_dir_t           w_dir_nxt;
      logic                r_breathe;
      logic [PWM_BITS-1:0] r_ramp;
      logic [PWM_BITS-1:0] w_ramp_nxt;

      always_ff @(negedge pin_clk_16M) begin
         if (!pin_reset_n) begin
            r_dir <= RAMP_UP;
         end else if (w_sel) begin
            r_dir <= RAMP_UP;
         end else if (w_step) begin
            r_dir <= w_dir_nxt;
         end
      end

      // Turn around on the step that would leave the range, so endpoints last one step
      always_comb begin
         w_dir_nxt = r_dir;
         case (r_dir)
            RAMP_UP:   if (&r_ramp)       w_dir_nxt = RAMP_DOWN;
            RAMP_DOWN: if (r_ramp == '0)  w_dir_nxt = RAMP_UP;
            default:   w_dir_nxt = RAMP_UP;
         endcase
      end

      always_comb begin
         w_ramp_nxt = r_ramp;
         if (w_dir_nxt == RAMP_UP) w_ramp_nxt = r_ramp + PWM_BITS'(1);
         else                      w_ramp_nxt = r_ramp - PWM_BITS'(1);
      end

      always_ff @(negedge pin_clk_16M) begin
         if (!pin_reset_n) begin
            r_breathe <= 1'b0;
            r_ramp    <= '0;
         end else if (w_sel) begin
            r_breathe <= cfg_breathe;
            r_ramp    <= '0;
         end else if (w_step) begin
            r_ramp    <= w_ramp_nxt;
         end
      end

      assign w_eff_duty = r_breathe ? r_ramp : r_duty;
`else
      assign w_eff_duty = r_duty;
`endif

      always_comb begin
         w_led = 1'b0;
         case (r_mode)
            2'd0:    w_led = 1'b0;
            2'd1:    w_led = 1'b1;
            2'd2:    w_led = r_count[BLINK_BIT] ^ r_invert;
            2'd3:    w_led = (r_count[PWM_BITS-1:0] < w_eff_duty);
            default: w_led = 1'b0;
         endcase
      end

      assign w_led_nxt[i] = w_led;
   end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver (falling-edge design, sampled on rising edge).
// NUM_LEDS=3 so that an out-of-range channel (3) is expressible in the 2-bit channel field.
module tb_led_pattern_driver;

   localparam int NUM_LEDS = 3;
   localparam int PWM_BITS = 4;

   logic                clk = 1'b1;
   logic                rst_n = 1'b0;
   logic                cfg_we = 1'b0;
   logic [1:0]          cfg_chan = '0;
   logic [1:0]          cfg_mode = '0;
   logic [PWM_BITS-1:0] cfg_duty = '0;
   logic                cfg_invert = 1'b0;
   logic                cfg_breathe = 1'b0;
   logic                cfg_ack;
   logic                cfg_err;
   logic [NUM_LEDS-1:0] leds;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   led_pattern_driver #(
      .NUM_LEDS(NUM_LEDS), .CNT_WIDTH(32), .BLINK_BIT(3),
      .PWM_BITS(PWM_BITS), .BREATHE_SHIFT(2)
   ) dut (
      .pin_clk_16M(clk), .pin_reset_n(rst_n), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
      .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_invert(cfg_invert),
      .cfg_breathe(cfg_breathe), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .leds(leds)
   );

   // Called just after a rising edge; returns just after the rising edge following the write.
   task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [PWM_BITS-1:0] duty,
                     input logic inv, input logic br);
      cfg_we = 1'b1; cfg_chan = ch; cfg_mode = mode; cfg_duty = duty;
      cfg_invert = inv; cfg_breathe = br;
      @(posedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      checks++; if (leds !== 3'b000) begin failures++; $display("FAIL reset_leds got=%b exp=000", leds); end
      checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", cfg_ack); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
      rst_n = 1'b1;
      @(posedge clk);
      checks++;
      if (dut.r_count !== 32'd1) begin failures++; $display("FAIL reset_count got=%0d exp=1", dut.r_count); end
   endtask

   task automatic test_blink;
      int last_t;
      logic prev;
      wr(2'd0, 2'd2, '0, 1'b0, 1'b0);
      wr(2'd1, 2'd2, '0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      prev = leds[0];
      last_t = -1;
      for (int t = 0; t < 48; t++) begin
         @(posedge clk);
         checks++;
         if (leds[1] !== ~leds[0]) begin failures++; $display("FAIL blink_complement t=%0d got=%b exp=%b", t, leds[1], ~leds[0]); end
         checks++;
         if (leds[2] !== 1'b0) begin failures++; $display("FAIL blink_idle_ch2 t=%0d got=%b exp=0", t, leds[2]); end
         if (leds[0] !== prev) begin
            if (last_t >= 0) begin
               checks++;
               if (t - last_t != 8) begin failures++; $display("FAIL blink_period got=%0d exp=8", t - last_t); end
            end
            last_t = t;
         end
         prev = leds[0];
      end
      checks++;
      if (last_t < 0) begin failures++; $display("FAIL blink_toggle got=none exp=toggles"); end
   endtask

   task automatic test_pwm;
      logic [PWM_BITS-1:0] duties [3];
      int highs;
      duties[0] = 4'd5; duties[1] = 4'd0; duties[2] = 4'd15;
      for (int k = 0; k < 3; k++) begin
         wr(2'd2, 2'd3, duties[k], 1'b0, 1'b0);
         repeat (2) @(posedge clk);
         highs = 0;
         for (int t = 0; t < 16; t++) begin
            @(posedge clk);
            if (leds[2] === 1'b1) highs++;
         end
         checks++;
         if (highs != int'(duties[k])) begin
            failures++; $display("FAIL pwm_duty%0d high_cycles got=%0d exp=%0d", duties[k], highs, duties[k]);
         end
      end
   endtask

   task automatic test_handshake;
      wr(2'd2, 2'd0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      cfg_we = 1'b1; cfg_chan = 2'd2; cfg_mode = 2'd1; cfg_duty = '0; cfg_invert = 1'b0; cfg_breathe = 1'b0;
      @(posedge clk);
      cfg_we = 1'b0;
      checks++; if (cfg_ack !== 1'b1) begin failures++; $display("FAIL ack_pulse got=%b exp=1", cfg_ack); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL ack_no_err got=%b exp=0", cfg_err); end
      checks++; if (leds[2] !== 1'b0) begin failures++; $display("FAIL ack_latency got=%b exp=0", leds[2]); end
      @(posedge clk);
      checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL ack_single got=%b exp=0", cfg_ack); end
      checks++; if (leds[2] !== 1'b1) begin failures++; $display("FAIL ack_led_on got=%b exp=1", leds[2]); end

      wr(2'd0, 2'd1, '0, 1'b0, 1'b0);
      wr(2'd1, 2'd0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      checks++; if (leds !== 3'b101) begin failures++; $display("FAIL err_setup got=%b exp=101", leds); end
      cfg_we = 1'b1; cfg_chan = 2'd3; cfg_mode = 2'd0; cfg_duty = '0;
      @(posedge clk);
      cfg_we = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
      checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL err_no_ack got=%b exp=0", cfg_ack); end
      @(posedge clk);
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL err_single got=%b exp=0", cfg_err); end
      for (int t = 0; t < 3; t++) begin
         checks++; if (leds !== 3'b101) begin failures++; $display("FAIL err_leds_kept t=%0d got=%b exp=101", t, leds); end
         @(posedge clk);
      end
   endtask

   task automatic test_back_to_back;
      wr(2'd0, 2'd0, '0, 1'b0, 1'b0);
      wr(2'd1, 2'd0, '0, 1'b0, 1'b0);
      wr(2'd2, 2'd0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      checks++; if (leds !== 3'b000) begin failures++; $display("FAIL b2b_setup got=%b exp=000", leds); end
      cfg_we = 1'b1; cfg_chan = 2'd0; cfg_mode = 2'd1;
      @(posedge clk);
      checks++; if (cfg_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack1 got=%b exp=1", cfg_ack); end
      cfg_chan = 2'd1;
      @(posedge clk);
      cfg_we = 1'b0;
      checks++; if (cfg_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack2 got=%b exp=1", cfg_ack); end
      @(posedge clk);
      checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL b2b_ack_end got=%b exp=0", cfg_ack); end
      checks++; if (leds !== 3'b011) begin failures++; $display("FAIL b2b_leds got=%b exp=011", leds); end

      // Same channel twice: the later write wins
      wr(2'd1, 2'd1, '0, 1'b0, 1'b0);
      wr(2'd1, 2'd0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      checks++; if (leds !== 3'b001) begin failures++; $display("FAIL last_write_wins got=%b exp=001", leds); end
   endtask

   task automatic test_reset_with_write;
      rst_n = 1'b0;
      cfg_we = 1'b1; cfg_chan = 2'd2; cfg_mode = 2'd1;
      @(posedge clk);
      checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL rstwr_ack got=%b exp=0", cfg_ack); end
      checks++; if (leds !== 3'b000) begin failures++; $display("FAIL rstwr_leds got=%b exp=000", leds); end
      rst_n = 1'b1; cfg_we = 1'b0;
      repeat (2) @(posedge clk);
      checks++; if (leds !== 3'b000) begin failures++; $display("FAIL rstwr_no_capture got=%b exp=000", leds); end
      checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL rstwr_ack_after got=%b exp=0", cfg_ack); end
   endtask

   task automatic test_breathe;
`ifdef LED_BREATHE_EN
      logic [PWM_BITS-1:0] prev, cur, exp_v;
      logic up;
      int last_t, changes;
      wr(2'd0, 2'd3, '0, 1'b0, 1'b1);
      prev = dut.g_chan[0].r_ramp;
      checks++; if (prev !== '0) begin failures++; $display("FAIL breathe_start got=%0d exp=0", prev); end
      exp_v = '0; up = 1'b1; last_t = -1; changes = 0;
      for (int t = 0; t < 160; t++) begin
         @(posedge clk);
         cur = dut.g_chan[0].r_ramp;
         if (cur !== prev) begin
            if (up) begin
               if (exp_v == 4'd15) begin exp_v = 4'd14; up = 1'b0; end
               else exp_v = exp_v + 4'd1;
            end else begin
               if (exp_v == 4'd0) begin exp_v = 4'd1; up = 1'b1; end
               else exp_v = exp_v - 4'd1;
            end
            checks++;
            if (cur !== exp_v) begin failures++; $display("FAIL breathe_value t=%0d got=%0d exp=%0d", t, cur, exp_v); end
            if (last_t >= 0) begin
               checks++;
               if (t - last_t != 4) begin failures++; $display("FAIL breathe_step got=%0d exp=4", t - last_t); end
            end
            last_t = t;
            changes++;
         end
         prev = cur;
      end
      checks++;
      if (changes < 38) begin failures++; $display("FAIL breathe_steps got=%0d exp>=38", changes); end
`else
      int highs;
      wr(2'd0, 2'd3, '0, 1'b0, 1'b1);
      highs = 0;
      for (int t = 0; t < 64; t++) begin
         @(posedge clk);
         if (leds[0] !== 1'b0) highs++;
      end
      checks++;
      if (highs != 0) begin failures++; $display("FAIL breathe_off_duty0 high_cycles got=%0d exp=0", highs); end
`endif
   endtask

   initial begin
      @(posedge clk);
      test_reset();
      test_blink();
      test_pwm();
      test_handshake();
      test_back_to_back();
      test_reset_with_write();
      test_breathe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
